// File: rtl/eng_pipe_sched.sv
// eng_pipe_sched: multi-context pipeline scheduler.
//
// Keeps a small state machine and a PC per hardware context, picks READY
// contexts round-robin into a single issue register towards the fa stage,
// and retires / re-arms contexts when the ca stage returns a commit.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   i_start_vld/ctx/pc         start an IDLE context at the given PC
//   i_kill_vld/ctx             kill a context (READY->IDLE, ISSUE/INFLIGHT->KILLED)
//   o_fa_vld/ctx/pc, i_fa_rdy  issue handshake towards the fa stage
//   i_ca_vld/ctx/pc/halt       commit return from the ca stage
//   o_busy_cnt, o_idle         registered count of non-IDLE contexts / all idle
//   o_err                      one-cycle pulse on an illegal start or commit
//   dbg_ctx_state              packed per-context state, 3 bits per context
//
// Handshake: o_fa_vld/o_fa_ctx/o_fa_pc form one transfer that completes on
// any edge where o_fa_vld && i_fa_rdy. Once o_fa_vld is high, the payload
// and o_fa_vld stay unchanged until that edge. o_fa_vld does not depend
// combinationally on i_fa_rdy.
module eng_pipe_sched #(
    parameter int N_CTX = 4,
    parameter int PC_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start_vld,
    input  logic [$clog2(N_CTX)-1:0]   i_start_ctx,
    input  logic [PC_W-1:0]            i_start_pc,
    input  logic                       i_kill_vld,
    input  logic [$clog2(N_CTX)-1:0]   i_kill_ctx,
    output logic                       o_fa_vld,
    input  logic                       i_fa_rdy,
    output logic [$clog2(N_CTX)-1:0]   o_fa_ctx,
    output logic [PC_W-1:0]            o_fa_pc,
    input  logic                       i_ca_vld,
    input  logic [$clog2(N_CTX)-1:0]   i_ca_ctx,
    input  logic [PC_W-1:0]            i_ca_pc,
    input  logic                       i_ca_halt,
    output logic [$clog2(N_CTX):0]     o_busy_cnt,
    output logic                       o_idle,
    output logic                       o_err,
    output logic [N_CTX*3-1:0]         dbg_ctx_state
);

    localparam int CW = $clog2(N_CTX);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READY    = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_INFLIGHT = 3'd3;
    localparam logic [2:0] ST_KILLED   = 3'd4;

    logic [2:0]      state_q [N_CTX];
    logic [2:0]      state_d [N_CTX];
    logic [PC_W-1:0] pc_q    [N_CTX];
    logic [PC_W-1:0] pc_d    [N_CTX];
    logic [CW-1:0]   rr_q;

    logic            fa_vld_q;
    logic [CW-1:0]   fa_ctx_q;
    logic [PC_W-1:0] fa_pc_q;
    logic [CW:0]     busy_q;
    logic            idle_q;
    logic            err_q;

    logic [N_CTX-1:0] cand;
    logic             grant_vld;
    logic [CW-1:0]    grant_ctx;
    logic [CW-1:0]    idx;
    logic             load_op;
    logic             accept;
    logic             issue_load;
    logic             start_err;
    logic             ca_err;
    logic [CW:0]      busy_d;

    assign load_op    = !fa_vld_q || i_fa_rdy;
    assign accept     = fa_vld_q && i_fa_rdy;
    assign issue_load = load_op && grant_vld;

    // Round-robin pick. A READY context being killed this cycle is not a
    // candidate, so a kill never races with its own issue. The loop runs
    // from the far end towards rr_q so the closest candidate is written last.
    always_comb begin
        cand      = '0;
        grant_vld = 1'b0;
        grant_ctx = '0;
        idx       = '0;
        for (int i = 0; i < N_CTX; i++) begin
            cand[i] = (state_q[i] == ST_READY) &&
                      !(i_kill_vld && (i_kill_ctx == CW'(i)));
        end
        for (int k = N_CTX - 1; k >= 0; k--) begin
            idx = rr_q + CW'(k);
            if (cand[idx]) begin
                grant_vld = 1'b1;
                grant_ctx = idx;
            end
        end
    end

    // Per-context next state. A kill on a context overrides every other
    // event on that context (including start and commit); the remaining
    // events are mutually exclusive by the state they require.
    always_comb begin
        start_err = 1'b0;
        ca_err    = 1'b0;
        busy_d    = '0;
        for (int i = 0; i < N_CTX; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            if (i_kill_vld && (i_kill_ctx == CW'(i))) begin
                if (i_ca_vld && (i_ca_ctx == CW'(i))) begin
                    state_d[i] = ST_IDLE;
                end else begin
                    case (state_q[i])
                        ST_READY:    state_d[i] = ST_IDLE;
                        ST_ISSUE:    state_d[i] = ST_KILLED;
                        ST_INFLIGHT: state_d[i] = ST_KILLED;
                        default:     state_d[i] = state_q[i];
                    endcase
                end
            end else begin
                if (i_start_vld && (i_start_ctx == CW'(i))) begin
                    if (state_q[i] == ST_IDLE) begin
                        state_d[i] = ST_READY;
                        pc_d[i]    = i_start_pc;
                    end else begin
                        start_err = 1'b1;
                    end
                end
                if (i_ca_vld && (i_ca_ctx == CW'(i))) begin
                    case (state_q[i])
                        ST_INFLIGHT: begin
                            if (i_ca_halt) begin
                                state_d[i] = ST_IDLE;
                            end else begin
                                state_d[i] = ST_READY;
                                pc_d[i]    = i_ca_pc;
                            end
                        end
                        ST_KILLED: state_d[i] = ST_IDLE;
                        default:   ca_err = 1'b1;
                    endcase
                end
                if (accept && (fa_ctx_q == CW'(i)) && (state_q[i] == ST_ISSUE)) begin
                    state_d[i] = ST_INFLIGHT;
                end
                if (issue_load && (grant_ctx == CW'(i))) begin
                    state_d[i] = ST_ISSUE;
                end
            end
            if (state_d[i] != ST_IDLE) begin
                busy_d = busy_d + {{CW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CTX; i++) begin
                state_q[i] <= ST_IDLE;
                pc_q[i]    <= '0;
            end
            rr_q     <= '0;
            fa_vld_q <= 1'b0;
            fa_ctx_q <= '0;
            fa_pc_q  <= '0;
            busy_q   <= '0;
            idle_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CTX; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
            end
            if (load_op) begin
                fa_vld_q <= grant_vld;
                if (grant_vld) begin
                    fa_ctx_q <= grant_ctx;
                    fa_pc_q  <= pc_q[grant_ctx];
                end
            end
            if (issue_load) begin
                rr_q <= grant_ctx + CW'(1);
            end
            // Counting the next state keeps the registered count aligned
            // with the state vector it describes.
            busy_q <= busy_d;
            idle_q <= (busy_d == '0);
            err_q  <= start_err | ca_err;
        end
    end

    always_comb begin
        dbg_ctx_state = '0;
        for (int i = 0; i < N_CTX; i++) begin
            dbg_ctx_state[i*3 +: 3] = state_q[i];
        end
    end

    assign o_fa_vld   = fa_vld_q;
    assign o_fa_ctx   = fa_ctx_q;
    assign o_fa_pc    = fa_pc_q;
    assign o_busy_cnt = busy_q;
    assign o_idle     = idle_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_eng_pipe_sched.sv
module tb_eng_pipe_sched;

    localparam int N_CTX = 4;
    localparam int PC_W  = 16;
    localparam int CW    = 2;

    typedef enum logic [2:0] {
        M_IDLE     = 3'd0,
        M_READY    = 3'd1,
        M_ISSUE    = 3'd2,
        M_INFLIGHT = 3'd3,
        M_KILLED   = 3'd4
    } ctx_state_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start_vld = 1'b0;
    logic [CW-1:0]     start_ctx = '0;
    logic [PC_W-1:0]   start_pc  = '0;
    logic              kill_vld  = 1'b0;
    logic [CW-1:0]     kill_ctx  = '0;
    logic              fa_rdy    = 1'b0;
    logic              ca_vld    = 1'b0;
    logic [CW-1:0]     ca_ctx    = '0;
    logic [PC_W-1:0]   ca_pc     = '0;
    logic              ca_halt   = 1'b0;

    logic              fa_vld;
    logic [CW-1:0]     fa_ctx;
    logic [PC_W-1:0]   fa_pc;
    logic [CW:0]       busy_cnt;
    logic              idle;
    logic              err;
    logic [N_CTX*3-1:0] dbg;

    eng_pipe_sched #(.N_CTX(N_CTX), .PC_W(PC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start_vld   (start_vld),
        .i_start_ctx   (start_ctx),
        .i_start_pc    (start_pc),
        .i_kill_vld    (kill_vld),
        .i_kill_ctx    (kill_ctx),
        .o_fa_vld      (fa_vld),
        .i_fa_rdy      (fa_rdy),
        .o_fa_ctx      (fa_ctx),
        .o_fa_pc       (fa_pc),
        .i_ca_vld      (ca_vld),
        .i_ca_ctx      (ca_ctx),
        .i_ca_pc       (ca_pc),
        .i_ca_halt     (ca_halt),
        .o_busy_cnt    (busy_cnt),
        .o_idle        (idle),
        .o_err         (err),
        .dbg_ctx_state (dbg)
    );

    // ---------------- scoreboard / counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;
    logic [CW+PC_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    ctx_state_t      m_st [N_CTX];
    int              m_pc [N_CTX];
    int              m_rr;
    logic            m_iss_vld;
    int              m_iss_ctx;
    int              m_iss_pc;
    logic            m_err;
    int              m_busy;

    // Advances the model over one clock edge using the inputs the DUT saw.
    task automatic model_step();
        ctx_state_t old_st [N_CTX];
        int  g;
        logic acc, can_load, kill_same_ca;
        if (rst) begin
            for (int i = 0; i < N_CTX; i++) begin
                m_st[i] = M_IDLE;
                m_pc[i] = 0;
            end
            m_rr = 0; m_iss_vld = 1'b0; m_iss_ctx = 0; m_iss_pc = 0;
            m_err = 1'b0; m_busy = 0;
            exp_q.delete();
            return;
        end
        old_st   = m_st;
        acc      = m_iss_vld && fa_rdy;
        can_load = !m_iss_vld || fa_rdy;
        g = -1;
        for (int k = 0; k < N_CTX; k++) begin
            int c;
            c = (m_rr + k) % N_CTX;
            if (g < 0 && old_st[c] == M_READY && !(kill_vld && int'(kill_ctx) == c)) g = c;
        end
        m_err = 1'b0;
        if (start_vld && !(kill_vld && kill_ctx == start_ctx)) begin
            if (old_st[start_ctx] == M_IDLE) begin
                m_st[start_ctx] = M_READY;
                m_pc[start_ctx] = int'(start_pc);
            end else m_err = 1'b1;
        end
        if (ca_vld && !(kill_vld && kill_ctx == ca_ctx)) begin
            if (old_st[ca_ctx] == M_INFLIGHT) begin
                m_st[ca_ctx] = ca_halt ? M_IDLE : M_READY;
                if (!ca_halt) m_pc[ca_ctx] = int'(ca_pc);
            end else if (old_st[ca_ctx] == M_KILLED) begin
                m_st[ca_ctx] = M_IDLE;
            end else m_err = 1'b1;
        end
        if (acc && old_st[m_iss_ctx] == M_ISSUE) m_st[m_iss_ctx] = M_INFLIGHT;
        if (can_load) begin
            if (g >= 0) begin
                m_st[g]   = M_ISSUE;
                m_iss_vld = 1'b1;
                m_iss_ctx = g;
                m_iss_pc  = m_pc[g];
                m_rr      = (g + 1) % N_CTX;
                exp_q.push_back({CW'(g), PC_W'(m_pc[g])});
            end else m_iss_vld = 1'b0;
        end
        if (kill_vld) begin
            kill_same_ca = ca_vld && (ca_ctx == kill_ctx);
            if (kill_same_ca) m_st[kill_ctx] = M_IDLE;
            else if (old_st[kill_ctx] == M_READY) m_st[kill_ctx] = M_IDLE;
            else if (old_st[kill_ctx] == M_ISSUE || old_st[kill_ctx] == M_INFLIGHT)
                m_st[kill_ctx] = M_KILLED;
        end
        m_busy = 0;
        for (int i = 0; i < N_CTX; i++) if (m_st[i] != M_IDLE) m_busy++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N_CTX*3-1:0] exp_dbg;
            logic [CW+PC_W-1:0] exp_item;
            for (int i = 0; i < N_CTX; i++) exp_dbg[i*3 +: 3] = m_st[i];
            check("fa_vld", 32'(fa_vld), 32'(m_iss_vld));
            check("err", 32'(err), 32'(m_err));
            check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
            check("idle", 32'(idle), 32'(m_busy == 0));
            check("ctx_state", 32'(dbg), 32'(exp_dbg));
            if (!rst && fa_vld && fa_rdy) begin
                if (exp_q.size() == 0) begin
                    check("fa_unexpected_issue", 32'({fa_ctx, fa_pc}), 32'hFFFF_FFFF);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("fa_issue", 32'({fa_ctx, fa_pc}), 32'(exp_item));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic clear_inputs();
        start_vld = 1'b0;
        kill_vld  = 1'b0;
        ca_vld    = 1'b0;
        ca_halt   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_start(input int c, input int pc);
        start_vld = 1'b1; start_ctx = CW'(c); start_pc = PC_W'(pc);
    endtask

    task automatic drive_commit(input int c, input int pc, input logic halt);
        ca_vld = 1'b1; ca_ctx = CW'(c); ca_pc = PC_W'(pc); ca_halt = halt;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check("reset_fa_vld", 32'(fa_vld), 32'd0);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_fa_pc", 32'(fa_pc), 32'd0);

        // Start ctx2, issue two cycles later, commit and reissue at the new PC.
        fa_rdy = 1'b1;
        drive_start(2, 16'h0100);
        tick(); clear_inputs();
        tick();
        check("lat2_vld", 32'(fa_vld), 32'd1);
        check("lat2_ctx", 32'(fa_ctx), 32'd2);
        check("lat2_pc", 32'(fa_pc), 32'h0100);
        tick();
        drive_commit(2, 16'h0104, 1'b0);
        tick(); clear_inputs();
        tick();
        check("reissue_ctx", 32'(fa_ctx), 32'd2);
        check("reissue_pc", 32'(fa_pc), 32'h0104);
        tick();
        drive_commit(2, 0, 1'b1);
        tick(); clear_inputs();
        tick();

        // Four starts back to back, round-robin issue order, then reset mid-flight.
        do_reset();
        fa_rdy = 1'b1;
        for (int i = 0; i < N_CTX; i++) begin
            drive_start(i, 16'h0200 + 16 * i);
            tick();
        end
        clear_inputs();
        check("busy_four", 32'(busy_cnt), 32'd4);
        check("busy_four_vld", 32'(fa_vld), 32'd1);
        rst = 1'b1;
        drive_start(1, 16'h0BAD);
        drive_commit(0, 16'h0BAD, 1'b0);
        tick();
        rst = 1'b0; clear_inputs();
        check("rst_mid_vld", 32'(fa_vld), 32'd0);
        check("rst_mid_idle", 32'(idle), 32'd1);
        check("rst_mid_busy", 32'(busy_cnt), 32'd0);
        drive_commit(0, 16'h0300, 1'b0);
        tick(); clear_inputs();
        check("late_commit_err", 32'(err), 32'd1);
        tick();
        check("late_commit_err_clr", 32'(err), 32'd0);

        // Stall with ctx1 presented, then accept.
        fa_rdy = 1'b0;
        drive_start(1, 16'h0020);
        tick(); clear_inputs();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_vld", 32'(fa_vld), 32'd1);
            check("stall_ctx", 32'(fa_ctx), 32'd1);
            check("stall_pc", 32'(fa_pc), 32'h0020);
            tick();
        end
        fa_rdy = 1'b1;
        tick();
        check("accept_inflight", 32'(dbg[5:3]), 32'(M_INFLIGHT));

        // Kill while in flight, then the commit returns and is swallowed.
        kill_vld = 1'b1; kill_ctx = 2'd1;
        tick(); clear_inputs();
        check("killed_state", 32'(dbg[5:3]), 32'(M_KILLED));
        drive_commit(1, 16'h0030, 1'b0);
        tick(); clear_inputs();
        check("kill_commit_idle", 32'(dbg[5:3]), 32'(M_IDLE));
        check("kill_commit_err", 32'(err), 32'd0);
        check("kill_commit_busy", 32'(busy_cnt), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // Illegal commit and illegal start.
        drive_commit(3, 16'h0040, 1'b0);
        tick(); clear_inputs();
        check("idle_commit_err", 32'(err), 32'd1);
        tick();
        check("idle_commit_pulse", 32'(err), 32'd0);
        drive_start(0, 16'h0040);
        tick();
        drive_start(0, 16'h0050);
        tick(); clear_inputs();
        check("dup_start_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int live[$];
            clear_inputs();
            rst    = ($urandom_range(0, 199) == 0);
            fa_rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 30)
                drive_start($urandom_range(0, N_CTX - 1), $urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 99) < 8) begin
                kill_vld = 1'b1;
                kill_ctx = CW'($urandom_range(0, N_CTX - 1));
            end
            for (int i = 0; i < N_CTX; i++)
                if (m_st[i] == M_INFLIGHT || m_st[i] == M_KILLED) live.push_back(i);
            if ($urandom_range(0, 99) < 45) begin
                int c;
                if (live.size() > 0 && $urandom_range(0, 99) < 85)
                    c = live[$urandom_range(0, live.size() - 1)];
                else
                    c = $urandom_range(0, N_CTX - 1);
                drive_commit(c, $urandom_range(0, 16'hFFFF), ($urandom_range(0, 99) < 25));
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
